// File: rtl/disp_arbiter_pkg.sv
// disp_arbiter_pkg: owner codes, blank segment code and blink masking helper for the display arbiter.
package disp_arbiter_pkg;
  localparam logic [1:0] OWNER_BASE = 2'd0;
  localparam logic [1:0] OWNER_NOTE = 2'd1;
  localparam logic [1:0] OWNER_MSG  = 2'd2;
  localparam logic [7:0] SEG_BLANK  = 8'h00;
  function automatic logic [63:0] blank_masked(input logic [63:0] d, input logic [7:0] m);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = m[i] ? SEG_BLANK : d[8*i +: 8];
    return r;
  endfunction
endpackage

// File: rtl/disp_arbiter_scan_timer.sv
// scan_timer: digit-step prescaler, 0..7 scan index and one-cycle frame-boundary pulse on the 7->0 wrap.
module scan_timer #(
  parameter int SCAN_PERIOD = 200000
) (
  input  logic       clk,
  input  logic       rst,
  output logic [2:0] scan,
  output logic       frame
);
  logic [31:0] presc;
  logic        tick;
  assign tick  = presc == 32'(SCAN_PERIOD - 1);
  assign frame = tick && scan == 3'd7;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
      scan  <= '0;
    end else begin
      presc <= tick ? '0 : presc + 32'd1;
      if (tick) scan <= scan + 3'd1;
    end
  end
endmodule

// File: rtl/disp_arbiter.sv
// disp_arbiter: frame-synchronous arbitration of the 8-digit display between base, note and message sources,
// with a one-entry message slot, hold timer, base blinking and registered digit scan outputs.
module disp_arbiter
  import disp_arbiter_pkg::*;
#(
  parameter int SCAN_PERIOD     = 200000,
  parameter int MSG_HOLD_FRAMES = 250,
  parameter int BLINK_FRAMES    = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] base_digits,
  input  logic [7:0]  blink_mask,
  input  logic        note_valid,
  input  logic [63:0] note_digits,
  input  logic        msg_req,
  input  logic [63:0] msg_digits,
  input  logic        msg_cancel,
  output logic        msg_ack,
  output logic        msg_busy,
  output logic [1:0]  owner,
  output logic [7:0]  seg_en,
  output logic [7:0]  tube1,
  output logic [7:0]  tube2
);
  logic [2:0]  scan;
  logic        frame;
  logic [63:0] msg_buf, frame_buf, win_digits;
  logic [15:0] hold_cnt, blink_cnt;
  logic        fresh, phase, accept, expire, msg_win, note_win;
  logic [7:0]  cur;
  scan_timer #(.SCAN_PERIOD(SCAN_PERIOD)) u_scan_timer (
    .clk   (clk),
    .rst   (rst),
    .scan  (scan),
    .frame (frame)
  );
  // fresh marks a slot message that has not yet owned a frame, so its hold count still needs loading
  assign accept     = !msg_busy && msg_req;
  assign expire     = owner == OWNER_MSG && !fresh && hold_cnt == 16'd1;
  assign msg_win    = msg_busy && !msg_cancel && !expire;
  assign note_win   = !msg_win && note_valid;
  assign win_digits = msg_win ? msg_buf : note_win ? note_digits
                    : blank_masked(base_digits, phase ? 8'h00 : blink_mask);
  assign cur        = frame_buf[{scan, 3'b000} +: 8];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      msg_ack   <= 1'b0;
      msg_busy  <= 1'b0;
      fresh     <= 1'b0;
      msg_buf   <= '0;
      frame_buf <= {8{SEG_BLANK}};
      owner     <= OWNER_BASE;
      hold_cnt  <= '0;
      blink_cnt <= '0;
      phase     <= 1'b1;
      seg_en    <= 8'h01;
      tube1     <= SEG_BLANK;
      tube2     <= SEG_BLANK;
    end else begin
      msg_ack <= accept;
      if (accept) begin
        msg_busy <= 1'b1;
        fresh    <= 1'b1;
        msg_buf  <= msg_digits;
      end else if (msg_busy && (msg_cancel || (frame && expire))) begin
        msg_busy <= 1'b0;
      end
      if (frame) begin
        frame_buf <= win_digits;
        owner     <= msg_win ? OWNER_MSG : note_win ? OWNER_NOTE : OWNER_BASE;
        hold_cnt  <= !msg_win ? '0 : fresh ? 16'(MSG_HOLD_FRAMES) : hold_cnt - 16'd1;
        if (msg_win) fresh <= 1'b0;
        blink_cnt <= blink_cnt == 16'(BLINK_FRAMES - 1) ? '0 : blink_cnt + 16'd1;
        if (blink_cnt == 16'(BLINK_FRAMES - 1)) phase <= !phase;
      end
      seg_en <= 8'd1 << scan;
      tube1  <= scan[2] ? SEG_BLANK : cur;
      tube2  <= scan[2] ? cur : SEG_BLANK;
    end
  end
endmodule
